// File: rtl/secuenciador_filtro.sv
// FIR sequencer: delay-line write, N_TAPS MAC address pairs, pipeline drain, listo pulse, DAC handshake.
// Optional macro SECUENCIADOR_CNT_OVERRUN_EN adds a saturating cnt_overrun[7:0] output.
module secuenciador_filtro #(
  parameter int N_TAPS  = 16,
  parameter int ADDR_W  = 4,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              muestra_valida,
  input  logic [11:0]       dato_adc,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [11:0]       mem_wdata,
  output logic [ADDR_W-1:0] coef_addr,
  output logic [ADDR_W-1:0] dato_addr,
  output logic              mac_clr,
  output logic              mac_en,
  output logic              listo,
  input  logic              dac_ocupado,
  output logic              dac_wr,
  output logic              ocupado,
`ifdef SECUENCIADOR_CNT_OVERRUN_EN
  output logic [7:0]        cnt_overrun,
`endif
  output logic              overrun
);

  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

  typedef enum logic [2:0] {IDLE, ESCRIBE, MAC, DRENA, LISTO, DAC, DAC_WR} estado_t;

  estado_t           estado, estado_sig;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_sig, k, k_sig, coef_sig, dato_sig;
  logic [DW-1:0]     d_cnt, d_sig;
  logic              mem_we_sig, mac_clr_sig, mac_en_sig, listo_sig, dac_wr_sig;
  logic              descarta;

  assign mem_waddr = wr_ptr;
  assign descarta  = muestra_valida && (estado != IDLE);

  always_comb begin
    estado_sig  = estado;
    wr_ptr_sig  = wr_ptr;
    k_sig       = k;
    d_sig       = d_cnt;
    mem_we_sig  = 1'b0;
    mac_clr_sig = 1'b0;
    mac_en_sig  = 1'b0;
    listo_sig   = 1'b0;
    dac_wr_sig  = 1'b0;
    coef_sig    = '0;
    dato_sig    = '0;
    // Outputs are computed for the next state so every strobe leaves a flop.
    case (estado)
      IDLE: if (muestra_valida) begin
        estado_sig  = ESCRIBE;
        mem_we_sig  = 1'b1;
        mac_clr_sig = 1'b1;
      end
      ESCRIBE: begin
        estado_sig = MAC;
        k_sig      = '0;
        mac_en_sig = 1'b1;
        dato_sig   = wr_ptr;
      end
      MAC: if (k == ADDR_W'(N_TAPS - 1)) begin
        estado_sig = DRENA;
        d_sig      = '0;
      end else begin
        k_sig      = k + ADDR_W'(1);
        mac_en_sig = 1'b1;
        coef_sig   = k + ADDR_W'(1);
        dato_sig   = wr_ptr - (k + ADDR_W'(1));
      end
      DRENA: if (d_cnt == DW'(MAC_LAT - 1)) begin
        estado_sig = LISTO;
        listo_sig  = 1'b1;
      end else begin
        d_sig = d_cnt + DW'(1);
      end
      LISTO, DAC: if (dac_ocupado) begin
        estado_sig = DAC;
      end else begin
        estado_sig = DAC_WR;
        dac_wr_sig = 1'b1;
      end
      DAC_WR: begin
        estado_sig = IDLE;
        wr_ptr_sig = wr_ptr + ADDR_W'(1);
      end
      default: estado_sig = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      estado    <= IDLE;
      wr_ptr    <= '0;
      k         <= '0;
      d_cnt     <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      coef_addr <= '0;
      dato_addr <= '0;
      mac_clr   <= 1'b0;
      mac_en    <= 1'b0;
      listo     <= 1'b0;
      dac_wr    <= 1'b0;
      ocupado   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      estado    <= estado_sig;
      wr_ptr    <= wr_ptr_sig;
      k         <= k_sig;
      d_cnt     <= d_sig;
      mem_we    <= mem_we_sig;
      coef_addr <= coef_sig;
      dato_addr <= dato_sig;
      mac_clr   <= mac_clr_sig;
      mac_en    <= mac_en_sig;
      listo     <= listo_sig;
      dac_wr    <= dac_wr_sig;
      ocupado   <= (estado_sig != IDLE);
      if (estado == IDLE && muestra_valida) mem_wdata <= dato_adc;
      if (descarta) overrun <= 1'b1;
    end
  end

`ifdef SECUENCIADOR_CNT_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (!reset_n)                           cnt_overrun <= '0;
    else if (descarta && cnt_overrun != 8'hFF) cnt_overrun <= cnt_overrun + 8'd1;
  end
`endif

endmodule

// File: tb/tb_secuenciador_filtro.sv
// Bench for secuenciador_filtro: per-cycle behavioural model plus directed literal checks.
module tb_secuenciador_filtro;
  localparam int N = 16, AW = 4, L = 2;

  logic          clk = 1'b0, reset_n, muestra_valida, dac_ocupado;
  logic [11:0]   dato_adc, mem_wdata;
  logic [AW-1:0] mem_waddr, coef_addr, dato_addr;
  logic          mem_we, mac_clr, mac_en, listo, dac_wr, ocupado, overrun;
`ifdef SECUENCIADOR_CNT_OVERRUN_EN
  logic [7:0]    cnt_overrun;
`endif

  int tests = 0, fails = 0;

  secuenciador_filtro #(.N_TAPS(N), .ADDR_W(AW), .MAC_LAT(L)) dut (
    .clk(clk), .reset_n(reset_n), .muestra_valida(muestra_valida), .dato_adc(dato_adc),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .coef_addr(coef_addr), .dato_addr(dato_addr), .mac_clr(mac_clr), .mac_en(mac_en),
    .listo(listo), .dac_ocupado(dac_ocupado), .dac_wr(dac_wr), .ocupado(ocupado),
`ifdef SECUENCIADOR_CNT_OVERRUN_EN
    .cnt_overrun(cnt_overrun),
`endif
    .overrun(overrun));

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a sequence is "cycle r since acceptance"; every output is a function of r.
  bit known = 0, active = 0, ov = 0;
  int r = 0, wr_at = -1, ptr = 0, samp = 0, cntov = 0;

  always @(negedge clk) begin
    bit was;
    int e_en;
    if (known) begin
      e_en = (active && r >= 2 && r <= N + 1) ? 1 : 0;
      check("ocupado",   ocupado,   active);
      check("mem_we",    mem_we,    active && r == 1);
      check("mac_clr",   mac_clr,   active && r == 1);
      check("mac_en",    mac_en,    e_en);
      check("coef_addr", coef_addr, e_en ? r - 2 : 0);
      check("dato_addr", dato_addr, e_en ? ((ptr - (r - 2)) % N + N) % N : 0);
      check("listo",     listo,     active && r == N + L + 2);
      check("dac_wr",    dac_wr,    active && r == wr_at);
      check("mem_waddr", mem_waddr, ptr);
      check("mem_wdata", mem_wdata, samp);
      check("overrun",   overrun,   ov);
`ifdef SECUENCIADOR_CNT_OVERRUN_EN
      check("cnt_overrun", cnt_overrun, cntov);
`endif
    end
    if (!reset_n) begin
      known = 1; active = 0; ptr = 0; samp = 0; ov = 0; cntov = 0; r = 0; wr_at = -1;
    end else if (known) begin
      was = active;
      if (active) begin
        if (r == wr_at) begin
          active = 0;
          ptr = (ptr + 1) % N;
        end else begin
          if (wr_at < 0 && r >= N + L + 2 && !dac_ocupado) wr_at = r + 1;
          r++;
        end
      end
      if (muestra_valida) begin
        if (was) begin
          ov = 1;
          if (cntov < 255) cntov++;
        end else begin
          active = 1; r = 1; wr_at = -1; samp = dato_adc;
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic run_sample();
    muestra_valida = 1'b1;
    dato_adc = 12'($urandom);
    step();
    muestra_valida = 1'b0;
    for (int i = 0; i < 60 && ocupado; i++) step();
    check("seq_done", ocupado, 0);
  endtask

  initial begin
    bit seen;
    reset_n = 1'b0; muestra_valida = 1'b0; dac_ocupado = 1'b0; dato_adc = '0;
    repeat (3) begin
      muestra_valida = 1'($urandom); dac_ocupado = 1'($urandom); dato_adc = 12'($urandom);
      step();
    end
    check("rst_outs", {mem_we, mac_en, mac_clr, listo, dac_wr, ocupado, overrun,
                       mem_waddr, coef_addr, dato_addr, mem_wdata}, 0);
    reset_n = 1'b1; muestra_valida = 1'b0; dac_ocupado = 1'b0;
    step();

    // First sample, strobe in cycle 0
    muestra_valida = 1'b1; dato_adc = 12'h800;
    step(); muestra_valida = 1'b0;                       // cycle 1
    check("t2_we", mem_we, 1); check("t2_waddr", mem_waddr, 0); check("t2_wdata", mem_wdata, 12'h800);
    step();                                              // cycle 2
    check("t2_en2", mac_en, 1); check("t2_coef2", coef_addr, 0); check("t2_dato2", dato_addr, 0);
    step();                                              // cycle 3
    check("t2_dato3", dato_addr, 15);
    step(14);                                            // cycle 17
    check("t2_coef17", coef_addr, 15); check("t2_dato17", dato_addr, 1);
    step(); check("t2_en18", mac_en, 0);                 // cycle 18
    step(2); check("t2_listo20", listo, 1);              // cycle 20
    step(); check("t2_wr21", dac_wr, 1);                 // cycle 21
    step(); check("t2_idle22", ocupado, 0);              // cycle 22

    // Second sample with a dropped strobe at cycle 5
    muestra_valida = 1'b1; dato_adc = 12'h123;
    step(); muestra_valida = 1'b0;                       // cycle 1
    check("t3_waddr", mem_waddr, 1);
    step(); check("t3_dato2", dato_addr, 1);
    step(); check("t3_dato3", dato_addr, 0);
    step(2); muestra_valida = 1'b1;                      // cycle 5
    step(); muestra_valida = 1'b0;                       // cycle 6
    check("t4_overrun", overrun, 1); check("t4_wdata", mem_wdata, 12'h123);
    step(14); check("t4_listo20", listo, 1);
    step(); check("t4_wr21", dac_wr, 1);
    step();

    repeat (14) run_sample();
    check("t3_wrap", mem_waddr, 0);

    // DAC busy for cycles 20..29
    muestra_valida = 1'b1;
    step(); muestra_valida = 1'b0;
    step(19); check("t5_listo", listo, 1); dac_ocupado = 1'b1;   // cycle 20
    step(5); check("t5_busy", {ocupado, dac_wr}, 2'b10);         // cycle 25
    step(5); check("t5_wr30", dac_wr, 0); dac_ocupado = 1'b0;    // cycle 30
    step(); check("t5_wr31", dac_wr, 1);
    step(); check("t5_after", {ocupado, dac_wr}, 2'b00);

    // Reset during MAC aborts
    muestra_valida = 1'b1;
    step(); muestra_valida = 1'b0;
    step(4); reset_n = 1'b0;                                     // cycle 5
    step(); reset_n = 1'b1;                                      // cycle 6
    check("t5_abort", {ocupado, mac_en, overrun, mem_waddr}, 0);
    seen = 0;
    repeat (25) begin step(); if (listo || dac_wr) seen = 1; end
    check("t5_no_listo", seen, 0);

`ifdef SECUENCIADOR_CNT_OVERRUN_EN
    muestra_valida = 1'b1;
    step(4); muestra_valida = 1'b0;                              // accepted + 3 dropped
    check("t6_cnt3", cnt_overrun, 3);
    muestra_valida = 1'b1;
    step(400); muestra_valida = 1'b0;
    check("t6_sat", cnt_overrun, 255);
    reset_n = 1'b0; step(); reset_n = 1'b1;
    check("t6_rst", cnt_overrun, 0);
`endif

    // Random traffic against the model
    repeat (3000) begin
      muestra_valida = ($urandom_range(7) == 0);
      dato_adc       = 12'($urandom);
      dac_ocupado    = ($urandom_range(2) == 0);
      reset_n        = !($urandom_range(499) == 0);
      step();
    end
    reset_n = 1'b1; muestra_valida = 1'b0; dac_ocupado = 1'b0;
    step(40);
    check("final_idle", ocupado, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
